// File: rtl/stack_display_pkg.sv
// rtl/stack_display_pkg.sv - shared state type, widths and add-3 helper for stack_display_decoder
package stack_display_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

   localparam int BCD_NIBBLE_W = 4;
   localparam int DIGIT_OUT_W  = 5;

   function automatic logic [BCD_NIBBLE_W-1:0] nibble_add3(input logic [BCD_NIBBLE_W-1:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with start/done handshake
module bin2bcd_seq
   import stack_display_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [WIDTH-1:0]                 din,
   output logic                             busy,
   output logic                             done,
   output logic [WIDTH-1:0]                 captured,
   output logic [BCD_NIBBLE_W*DIGITS-1:0]   result
);

   localparam int BW    = BCD_NIBBLE_W * DIGITS;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   conv_state_e      state_q, state_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [BW-1:0]    sr_q, sr_d;
   logic [BW-1:0]    adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      work_d  = work_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      for (int i = 0; i < DIGITS; i++)
         adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = nibble_add3(sr_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]);
      case (state_q)
         // value is latched on the way out of IDLE so later changes cannot leak in
         IDLE: if (start) begin
            cap_d   = din;
            state_d = LOAD;
         end
         LOAD: begin
            work_d  = cap_q;
            sr_d    = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            sr_d   = {adj[BW-2:0], work_q[WIDTH-1]};
            work_d = work_q << 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cap_q   <= '0;
         work_q  <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         work_q  <= work_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = (state_q == DONE);
   assign captured = cap_q;
   assign result   = sr_q;

endmodule

// File: rtl/stack_display_decoder.sv
// rtl/stack_display_decoder.sv - stack-top to multiplexed decimal display; STACK_DISPLAY_LZB_EN enables leading-zero blanking
module stack_display_decoder
   import stack_display_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DIGITS   = 10,
   parameter int SCAN_DIV = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [WIDTH-1:0]                  value,
   input  logic                              value_valid,
   output logic                              busy,
   output logic [BCD_NIBBLE_W*DIGITS-1:0]    bcd,
   output logic                              bcd_ready,
   output logic [DIGIT_OUT_W-1:0]            digit,
   output logic                              digit_valid,
   output logic [DIGITS-1:0]                 digit_sel
);

   localparam int BW    = BCD_NIBBLE_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic             start, conv_done;
   logic [WIDTH-1:0] captured;
   logic [BW-1:0]    conv_result;

   logic [BW-1:0]          bcd_q, bcd_d;
   logic                   bcd_ready_q, bcd_ready_d;
   logic [SCAN_DIV-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DIGIT_OUT_W-1:0] digit_q, digit_d;
   logic                   digit_valid_q, digit_valid_d;
   logic [DIGITS-1:0]      digit_sel_q, digit_sel_d;
   logic                   show;
`ifdef STACK_DISPLAY_LZB_EN
   logic [IDX_W-1:0]       msd;
`endif

   // a fresh conversion is needed whenever the shown result is missing or stale
   assign start = value_valid && (!bcd_ready_q || (value != captured));

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .din      (value),
      .busy     (busy),
      .done     (conv_done),
      .captured (captured),
      .result   (conv_result)
   );

   always_comb begin
      bcd_d       = bcd_q;
      bcd_ready_d = bcd_ready_q;
      if (conv_done) begin
         bcd_d       = conv_result;
         bcd_ready_d = 1'b1;
      end
      pre_d = pre_q + SCAN_DIV'(1);
      idx_d = idx_q;
      if (&pre_q) idx_d = (idx_q == IDX_W'(DIGITS-1)) ? '0 : idx_q + IDX_W'(1);
      show = value_valid & bcd_ready_q;
`ifdef STACK_DISPLAY_LZB_EN
      msd = '0;
      for (int i = 0; i < DIGITS; i++)
         if (bcd_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] != 4'd0) msd = IDX_W'(i);
      show = show & (idx_q <= msd);
`endif
      digit_sel_d   = DIGITS'(1) << idx_q;
      digit_d       = {1'b0, bcd_q[{idx_q, 2'b00} +: BCD_NIBBLE_W]};
      digit_valid_d = show;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q         <= '0;
         bcd_ready_q   <= 1'b0;
         pre_q         <= '0;
         idx_q         <= '0;
         digit_q       <= '0;
         digit_valid_q <= 1'b0;
         digit_sel_q   <= DIGITS'(1);
      end else begin
         bcd_q         <= bcd_d;
         bcd_ready_q   <= bcd_ready_d;
         pre_q         <= pre_d;
         idx_q         <= idx_d;
         digit_q       <= digit_d;
         digit_valid_q <= digit_valid_d;
         digit_sel_q   <= digit_sel_d;
      end
   end

   assign bcd         = bcd_q;
   assign bcd_ready   = bcd_ready_q;
   assign digit       = digit_q;
   assign digit_valid = digit_valid_q;
   assign digit_sel   = digit_sel_q;

endmodule

// File: tb/tb_stack_display_decoder.sv
// tb/tb_stack_display_decoder.sv - scoreboard bench for stack_display_decoder with a decimal reference model
module tb_stack_display_decoder;

   localparam int WIDTH    = 32;
   localparam int DIGITS   = 10;
   localparam int SCAN_DIV = 2;
   localparam int BW       = 4 * DIGITS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WIDTH-1:0]  value = '0;
   logic              value_valid = 1'b0;
   logic              busy;
   logic [BW-1:0]     bcd;
   logic              bcd_ready;
   logic [4:0]        digit;
   logic              digit_valid;
   logic [DIGITS-1:0] digit_sel;

   stack_display_decoder #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .value_valid (value_valid),
      .busy        (busy),
      .bcd         (bcd),
      .bcd_ready   (bcd_ready),
      .digit       (digit),
      .digit_valid (digit_valid),
      .digit_sel   (digit_sel)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [BW-1:0]    exp_bcd;
      logic [WIDTH-1:0] val;
      int unsigned      t0;
      bit               rel;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_shown = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [BW-1:0] ref_bcd(input longint unsigned v);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int num_digits(input longint unsigned v);
      int n;
      n = 1;
      while (v >= 10) begin
         v = v / 10;
         n++;
      end
      return n;
   endfunction

   function automatic bit exp_dvalid(input int p);
      bit ok;
      ok = value_valid && m_ready;
`ifdef STACK_DISPLAY_LZB_EN
      ok = ok && (p < num_digits(64'(m_shown)));
`else
      ok = ok && (p >= 0);
`endif
      return ok;
   endfunction

   // monitor: pops the scoreboard whenever a conversion finishes
   initial begin
      logic          prev_busy;
      logic [BW-1:0] prev_bcd;
      int unsigned   busy_cnt;
      int unsigned   last_done;
      bit            fell;
      exp_t          e;
      prev_busy = 1'b0;
      prev_bcd  = '0;
      busy_cnt  = 0;
      last_done = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
            prev_bcd  = bcd;
            m_ready   = 1'b0;
         end else begin
            fell = prev_busy && !busy;
            if (bcd !== prev_bcd) check("bcd_atomic", 64'(fell), 64'd1);
            if (busy) busy_cnt++;
            if (fell) begin
               check("result_expected", 64'(exp_q.size() != 0), 64'd1);
               check("bcd_ready_set", 64'(bcd_ready), 64'd1);
               check("busy_cycles", 64'(busy_cnt), 64'(WIDTH + 1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("bcd_result", 64'(bcd), 64'(e.exp_bcd));
                  if (e.rel) check("restart_gap", 64'(cyc - last_done), 64'(WIDTH + 3));
                  else       check("latency", 64'(cyc - e.t0), 64'(WIDTH + 2));
                  m_shown = e.val;
               end
               m_ready   = 1'b1;
               last_done = cyc;
               busy_cnt  = 0;
            end
            prev_busy = busy;
            prev_bcd  = bcd;
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] v, input bit rel);
      exp_t e;
      value       = v;
      value_valid = 1'b1;
      e.exp_bcd   = ref_bcd(64'(v));
      e.val       = v;
      e.t0        = cyc + 1;
      e.rel       = rel;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_vals();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_bcd_ready", 64'(bcd_ready), 64'd0);
      check("rst_digit", 64'(digit), 64'd0);
      check("rst_digit_valid", 64'(digit_valid), 64'd0);
      check("rst_digit_sel", 64'(digit_sel), 64'd1);
   endtask

   task automatic check_display(input int ncyc);
      logic [DIGITS-1:0] prev_sel;
      logic [DIGITS-1:0] nxt;
      logic [BW-1:0]     mb;
      int                run;
      bit                started;
      int                p;
      prev_sel = '0;
      run      = 0;
      started  = 0;
      mb       = ref_bcd(64'(m_shown));
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         check("sel_onehot", 64'($countones(digit_sel)), 64'd1);
         p = -1;
         for (int j = 0; j < DIGITS; j++) if (digit_sel[j]) p = j;
         if (p >= 0) begin
            check("digit", 64'(digit), 64'(mb[p*4 +: 4]));
            check("digit_valid", 64'(digit_valid), 64'(exp_dvalid(p)));
         end
         if (digit_sel != prev_sel) begin
            if (started) check("dwell", 64'(run), 64'(1 << SCAN_DIV));
            if (prev_sel != '0) begin
               nxt = prev_sel[DIGITS-1] ? DIGITS'(1) : (prev_sel << 1);
               check("sel_next", 64'(digit_sel), 64'(nxt));
               started = 1;
            end
            prev_sel = digit_sel;
            run      = 1;
         end else begin
            run++;
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] v;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals();
      @(negedge clk);
      rst = 1'b0;

      issue('0, 1'b0);
      wait_drain(100);
      check_display(50);

      issue(32'hFFFF_FFFF, 1'b0);
      wait_drain(100);
      check("max_value_bcd", 64'(bcd), 64'h42_9496_7295);

      issue(32'd123, 1'b0);
      repeat (10) @(negedge clk);
      issue(32'd456, 1'b1);
      wait_drain(150);

      issue(32'd305, 1'b0);
      wait_drain(100);
      check_display(100);

      issue(32'd7, 1'b0);
      repeat (5) @(negedge clk);
      value_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         check("dv_low_after_drop", 64'(digit_valid), 64'd0);
      end
      wait_drain(50);
      value_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("no_reconversion", 64'(busy), 64'd0);
      end
      check_display(50);

      value       = 32'd99;
      value_valid = 1'b1;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      issue(32'd99, 1'b0);
      wait_drain(100);
      check_display(50);

      for (int k = 0; k < 12; k++) begin
         v = (k % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 99999));
         while (v == m_shown) v = v + 32'd1;
         issue(v, 1'b0);
         wait_drain(100);
         if (k % 4 == 3) check_display(45);
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_display_decoder.md
# stack_display_decoder

Converts the 32-bit stack-top value into decimal digits and time-multiplexes them, one digit at a time, onto the existing single-digit `seven_seg` driver. It sits between the stack core (the stack-top item and the not-empty flag) and `seven_seg` (`digit`, `valid`), and adds a one-hot digit-select bus for a multi-digit common-cathode display. Conversion is sequential (double-dabble) and the scan runs continuously.

## Interface
- `WIDTH`, 32, binary input width
- `DIGITS`, 10, decimal digits produced; must satisfy 10^DIGITS > 2^WIDTH−1
- `SCAN_DIV`, 16, log2 of clock cycles each digit is shown
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `value`  in  WIDTH  stack-top item
- `value_valid`  in  1  stack not empty
- `busy`  out  1  conversion in progress
- `bcd`  out  4*DIGITS  converted digits, digit 0 (units) in bits [3:0]
- `bcd_ready`  out  1  `bcd` holds the conversion of the last captured value
- `digit`  out  5  BCD digit for `seven_seg.digit`, zero-extended
- `digit_valid`  out  1  drives `seven_seg.valid`; low shows a dash/blank
- `digit_sel`  out  DIGITS  one-hot active-high position select

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: if `value_valid` and (`bcd_ready`=0 or `value` ≠ captured value), go to LOAD. Otherwise stay.
- LOAD (1 cycle): capture `value`, clear the shift register, set `busy`=1, and clear the shift count.
- SHIFT (WIDTH cycles): each cycle, add 3 to every BCD nibble ≥5, then shift left one bit. The value MSB enters the units nibble. The count increments each cycle. Nibble adds use 4-bit arithmetic with no carry between nibbles.
- DONE (1 cycle): copy the shift register to `bcd` atomically, set `bcd_ready`=1 and `busy`=0, and return to IDLE.
- `value` changes during LOAD/SHIFT are ignored. The IDLE comparison restarts the conversion afterwards, so the latest value always converges.
- `bcd` is never partially updated; the old value is held until DONE.
- Scan: a free-running counter of SCAN_DIV+idx bits. The position index steps 0→DIGITS−1 and wraps to 0 every 2^SCAN_DIV cycles.
- Outputs (registered): `digit_sel`=1<<idx, `digit`={1'b0, bcd[idx]}.
- `digit_valid`=`value_valid` & `bcd_ready`, subject to blanking (see Configuration).
- `value_valid` low: `digit_valid`=0 on every position from the next cycle. Any running conversion still completes.

## Timing
- Reset values: `busy`=0, `bcd`=0, `bcd_ready`=0, `digit`=0, `digit_valid`=0, `digit_sel`=1 (position 0), FSM=IDLE, scan counter=0.
- Latency from `value` sampled in IDLE to `bcd` updated: WIDTH+2 cycles (LOAD + WIDTH SHIFT + DONE), i.e. 34 cycles at default width.
- Display outputs lag `bcd`/`value_valid` by 1 cycle.
- Position dwell is exactly 2^SCAN_DIV cycles. Position DIGITS−1 is followed by position 0.
- Reset asserted mid-conversion: everything returns to reset values on the next edge. The partial result is discarded.
- Simultaneous DONE and a new differing `value`: DONE completes. IDLE detects the mismatch next cycle and goes to LOAD on the following cycle.

## Configuration
- `STACK_DISPLAY_LZB_EN` defined: leading-zero blanking.
  - Any position above the most significant non-zero digit gets `digit_valid`=0.
  - Position 0 is always valid when valid, so value 0 shows "0".
- Not defined: all positions show digits, including leading zeros.

## Structure
- Package `stack_display_pkg` holds:
  - FSM state enum
  - `BCD_NIBBLE_W`=4
  - `DIGIT_OUT_W`=5
  - helper function: nibble add-3 correction
- Sub-module `bin2bcd_seq` holds the LOAD/SHIFT/DONE datapath and count, with a start/done handshake. The top level owns the IDLE comparison, the scan counter and blanking.

## Test plan
- Reset, then `value`=0 with `value_valid`=1 → after 34 cycles `bcd`=0, `bcd_ready`=1. Position 0 shows `digit`=0 with valid.
- `value`=4294967295 → `bcd` nibbles 4,2,9,4,9,6,7,2,9,5 (MSD→LSD) after 34 cycles, with `busy` high for exactly 33 cycles.
- `value`=123 then, 10 cycles later, 456 → first result 123 held until DONE, then 456 appears within 36 cycles of the end of the first conversion.
- `value`=7 with `value_valid` dropped during SHIFT, using SCAN_DIV=2 → `digit_valid`=0 on all positions the cycle after the drop. Raising `value_valid` again shows 7 with no new conversion.
- SCAN_DIV=2, value 305 → `digit_sel` cycles 1,2,4,… every 4 cycles, with `digit` 5,0,3. With LZB_EN, positions 3–9 are invalid. Without it, they are valid with 0.
- `rst` pulsed at cycle 15 of a conversion of 99 → all outputs return to reset values. A fresh conversion restarts and yields 99.
